layer_output_serializer: RTL and testbench

- Receiving end of the neuron output interface: collects one `out`/`outValid` result from each of NUM_NEURONS parallel neurons in a layer.
- Once every neuron has reported, streams the stored results one word per handshake as a serial input stream for the next layer's neurons.
- Sits between one neuron layer and the next, replacing the bench-side memory feeder that drives the `myInput`/`myInputValid` stream.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/capture_bank.sv | 74 +++++++
 rtl/layer_output_serializer.sv | 117 +++++++++++
 tb/tb_layer_output_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the neuron-layer datapath:
//               default result width, serializer state encoding, ReLU and
//               packed-bus slice offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    // Clamp a two's-complement result at zero
    function automatic logic [NN_DATA_WIDTH-1:0] relu(input logic signed [NN_DATA_WIDTH-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction

    // LSB position of slice k inside a packed bus of width-bit slices
    function automatic int slice_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_bank.sv
`default_nettype none
// ============================================================================
// Module      : capture_bank
// Description : Per-neuron result buffer with captured mask. A slot accepts
//               only its first strobe per frame; the optional activation
//               (LAYER_SERIALIZER_RELU_EN) is applied on capture.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_bank
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int DATA_WIDTH  = NN_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_enable,
    input  logic                              i_clear,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_neuron_out,
    input  logic [NUM_NEURONS-1:0]            i_neuron_valid,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] o_buf,
    output logic [NUM_NEURONS-1:0]            o_mask,
    output logic                              o_all_next,
    output logic [DATA_WIDTH-1:0]             o_first_word
);

    logic [NUM_NEURONS-1:0] r_mask;
    logic [NUM_NEURONS-1:0] w_take;
    logic [DATA_WIDTH-1:0]  r_buf [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  w_act [NUM_NEURONS];

    assign w_take       = i_neuron_valid & ~r_mask & {NUM_NEURONS{i_enable}};
    assign o_mask       = r_mask;
    assign o_all_next   = &(r_mask | w_take);
    // Slot 0 may be captured on the same edge that completes the frame
    assign o_first_word = r_mask[0] ? r_buf[0] : w_act[0];

    // Captured mask: set on first strobe, cleared on frame end or reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (i_clear) begin
            r_mask <= '0;
        end else begin
            r_mask <= r_mask | w_take;
        end
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] w_slice;
        assign w_slice = i_neuron_out[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH];

`ifdef LAYER_SERIALIZER_RELU_EN
        if (DATA_WIDTH == NN_DATA_WIDTH) begin : g_relu_pkg
            assign w_act[k] = relu(w_slice);
        end else begin : g_relu_generic
            assign w_act[k] = w_slice[DATA_WIDTH-1] ? '0 : w_slice;
        end
`else
        assign w_act[k] = w_slice;
`endif

        assign o_buf[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = r_buf[k];

        // Buffer slot: loaded only by the first strobe of the frame
        always_ff @(posedge clk) begin
            if (w_take[k]) begin
                r_buf[k] <= w_act[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer
// Description : Collects one result from each neuron of a layer, then streams
//               them in index order over a valid/ready interface. Optional
//               ReLU on capture when LAYER_SERIALIZER_RELU_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_output_serializer
    import nn_pkg::*;
#(
    parameter  int NUM_NEURONS = 4,
    parameter  int DATA_WIDTH  = NN_DATA_WIDTH,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuronOut,
    input  logic [NUM_NEURONS-1:0]            neuronOutValid,
    output logic [DATA_WIDTH-1:0]             layerOut,
    output logic                              layerOutValid,
    input  logic                              layerOutReady,
    output logic                              layerOutLast,
    output logic                              busy,
    output logic                              overrun
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_NEURONS - 1);

    state_t                            r_state;
    logic [IDX_W-1:0]                  r_idx;
    logic [DATA_WIDTH-1:0]             r_layer_out;
    logic                              r_valid;
    logic                              r_last;
    logic                              r_busy;
    logic                              r_overrun;

    logic [NUM_NEURONS*DATA_WIDTH-1:0] w_buf;
    logic [NUM_NEURONS-1:0]            w_mask;
    logic                              w_all_next;
    logic [DATA_WIDTH-1:0]             w_first_word;
    logic [IDX_W-1:0]                  w_idx_inc;
    logic                              w_last_hs;
    logic                              w_drop;

    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_last_hs = (r_state == SEND) && layerOutReady && (r_idx == c_last_idx);
    // In SEND every strobe is lost; in COLLECT only repeats are lost
    assign w_drop    = (r_state == SEND) ? (|neuronOutValid) : (|(neuronOutValid & w_mask));

    capture_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_capture_bank (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (r_state == COLLECT),
        .i_clear        (w_last_hs),
        .i_neuron_out   (neuronOut),
        .i_neuron_valid (neuronOutValid),
        .o_buf          (w_buf),
        .o_mask         (w_mask),
        .o_all_next     (w_all_next),
        .o_first_word   (w_first_word)
    );

    // Collect/send FSM with index counter and registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_layer_out <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= r_overrun | w_drop;
            case (r_state)
                COLLECT: begin
                    if (w_all_next) begin
                        r_state     <= SEND;
                        r_idx       <= '0;
                        r_layer_out <= w_first_word;
                        r_valid     <= 1'b1;
                        r_last      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (layerOutReady) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= COLLECT;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx       <= w_idx_inc;
                            r_layer_out <= w_buf[slice_lsb(int'(w_idx_inc), DATA_WIDTH) +: DATA_WIDTH];
                            r_last      <= (w_idx_inc == c_last_idx);
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign layerOut      = r_layer_out;
    assign layerOutValid = r_valid;
    assign layerOutLast  = r_last;
    assign busy          = r_busy;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_output_serializer
// Description : Self-checking bench for layer_output_serializer. Frames come
//               from a table plus random frames; the expected stream is the
//               list of first-captured values per neuron, emitted in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_output_serializer;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] neuronOut;
    logic [N-1:0]    neuronOutValid;
    logic [DW-1:0]   layerOut;
    logic            layerOutValid;
    logic            layerOutReady;
    logic            layerOutLast;
    logic            busy;
    logic            overrun;

    always #5 clk = ~clk;

    layer_output_serializer #(
        .NUM_NEURONS (N),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .neuronOut      (neuronOut),
        .neuronOutValid (neuronOutValid),
        .layerOut       (layerOut),
        .layerOutValid  (layerOutValid),
        .layerOutReady  (layerOutReady),
        .layerOutLast   (layerOutLast),
        .busy           (busy),
        .overrun        (overrun)
    );

    typedef struct packed {
        logic [N-1:0][DW-1:0] v;      // first value per neuron
        logic [N-1:0][7:0]    c;      // cycle of first strobe per neuron
        int                   dn;     // neuron that strobes again (-1: none)
        int                   dc;     // cycle of that repeat strobe
        logic [DW-1:0]        dv;     // value of the repeat strobe
        int                   rmode;  // 0 ready high, 1 low 5 cycles, 2 random
        logic                 sstrobe;// inject strobes while sending
    } frame_t;

    int            checks = 0;
    int            errors = 0;
    logic          exp_ovr;
    logic [DW-1:0] exp_w [N];
    frame_t        tbl [5];

    function automatic logic [DW-1:0] act(input logic [DW-1:0] x);
`ifdef LAYER_SERIALIZER_RELU_EN
        return ($signed(x) < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive the strobe schedule of one frame; valid must appear exactly after the last first-strobe
    task automatic collect(input frame_t f);
        int            cmax;
        logic [N*DW-1:0] d;
        logic [N-1:0]  v;
        cmax = 0;
        for (int k = 0; k < N; k++) begin
            if (int'(f.c[k]) > cmax) cmax = int'(f.c[k]);
            exp_w[k] = act(f.v[k]);
        end
        for (int t = 0; t <= cmax; t++) begin
            d = {$urandom, $urandom};
            v = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(f.c[k]) == t) begin
                    v[k] = 1'b1;
                    d[k*DW +: DW] = f.v[k];
                end
            end
            if (f.dn >= 0 && f.dc == t) begin
                v[f.dn] = 1'b1;
                d[f.dn*DW +: DW] = f.dv;
            end
            neuronOut      = d;
            neuronOutValid = v;
            @(posedge clk);
            #1;
            neuronOutValid = '0;
            if (f.dn >= 0 && f.dc == t) exp_ovr = 1'b1;
            if (t < cmax) begin
                chk("collect_valid_low", 32'(layerOutValid), 32'd0);
            end else begin
                chk("collect_valid_rise", 32'(layerOutValid), 32'd1);
                chk("collect_busy", 32'(busy), 32'd1);
                chk("collect_overrun", 32'(overrun), 32'(exp_ovr));
            end
        end
    endtask

    // Consume nwords words; while valid, the word shown must be the next expected one
    task automatic drain(input int rmode, input logic sstrobe, input int nwords);
        int   n;
        int   cyc;
        logic vs;
        logic st;
        n   = 0;
        cyc = 0;
        while (n < nwords && cyc < 60) begin
            case (rmode)
                0:       layerOutReady = 1'b1;
                1:       layerOutReady = (cyc >= 5);
                default: layerOutReady = 1'($urandom_range(0, 1));
            endcase
            vs = layerOutValid;
            chk("send_valid", 32'(vs), 32'd1);
            chk("send_word", 32'(layerOut), 32'(exp_w[n]));
            chk("send_last", 32'(layerOutLast), 32'(n == N - 1));
            chk("send_busy", 32'(busy), 32'd1);
            st = sstrobe && vs && ($urandom_range(0, 2) == 0);
            if (st) begin
                neuronOutValid = 4'($urandom_range(1, 15));
                neuronOut      = {$urandom, $urandom};
            end
            @(posedge clk);
            if (vs && layerOutReady) n++;
            if (st) exp_ovr = 1'b1;
            #1;
            neuronOutValid = '0;
            cyc++;
        end
        if (n < nwords) chk("drain_timeout", 32'(n), 32'(nwords));
        layerOutReady = 1'b1;
    endtask

    task automatic frame_end();
        chk("end_valid", 32'(layerOutValid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_last", 32'(layerOutLast), 32'd0);
        chk("end_overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic run_frame(input frame_t f);
        collect(f);
        drain(f.rmode, f.sstrobe, N);
        frame_end();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        exp_ovr = 1'b0;
        chk("rst_valid", 32'(layerOutValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(layerOutLast), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_word", 32'(layerOut), 32'd0);
    endtask

    initial begin
        frame_t f;
        int     cmax;
        int     k;

        rst            = 1'b0;
        neuronOut      = '0;
        neuronOutValid = '0;
        layerOutReady  = 1'b1;
        exp_ovr        = 1'b0;

        // Stagger: neurons 0..3 in cycles 1,3,4,7
        tbl[0] = '{v: {16'h7FFF, 16'hFFFE, 16'h0002, 16'h0001}, c: {8'd7, 8'd4, 8'd3, 8'd1},
                   dn: -1, dc: 0, dv: 16'h0, rmode: 0, sstrobe: 1'b0};
        // Simultaneous capture
        tbl[1] = '{v: {16'h0013, 16'h0012, 16'h0011, 16'h0010}, c: {8'd0, 8'd0, 8'd0, 8'd0},
                   dn: -1, dc: 0, dv: 16'h0, rmode: 0, sstrobe: 1'b0};
        // Backpressure: ready low for the first 5 cycles of valid
        tbl[2] = '{v: {16'h0013, 16'h0012, 16'h0011, 16'h0010}, c: {8'd0, 8'd0, 8'd0, 8'd0},
                   dn: -1, dc: 0, dv: 16'h0, rmode: 1, sstrobe: 1'b0};
        // Overrun: neuron 2 strobes 0x0005 then 0x0009, plus strobes while sending
        tbl[3] = '{v: {16'h0033, 16'h0005, 16'h0031, 16'h0030}, c: {8'd5, 8'd1, 8'd2, 8'd0},
                   dn: 2, dc: 3, dv: 16'h0009, rmode: 0, sstrobe: 1'b1};
        // Sign boundaries with random ready; overrun must stay set
        tbl[4] = '{v: {16'h8000, 16'hFFFF, 16'h1234, 16'h0000}, c: {8'd2, 8'd0, 8'd2, 8'd1},
                   dn: -1, dc: 0, dv: 16'h0, rmode: 2, sstrobe: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i]);
        end

        // Random frames
        for (int i = 0; i < 25; i++) begin
            cmax = 0;
            for (int j = 0; j < N; j++) begin
                f.v[j] = 16'($urandom);
                f.c[j] = 8'($urandom_range(0, 5));
                if (int'(f.c[j]) > cmax) cmax = int'(f.c[j]);
            end
            f.dn = -1;
            f.dc = 0;
            f.dv = 16'($urandom);
            k = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1 && int'(f.c[k]) < cmax) begin
                f.dn = k;
                f.dc = $urandom_range(int'(f.c[k]) + 1, cmax);
            end
            f.rmode   = 2;
            f.sstrobe = 1'($urandom_range(0, 1));
            run_frame(f);
        end

        // Reset mid-frame while word index 2 is on the output
        f = tbl[3];
        collect(f);
        drain(0, 1'b0, 2);
        chk("midframe_word", 32'(layerOut), 32'(exp_w[2]));
        do_reset();
        run_frame(tbl[1]);

        // Reset mid-collection: stale captures must not complete the next frame
        neuronOutValid = 4'b0011;
        neuronOut      = {$urandom, $urandom};
        @(posedge clk);
        #1;
        neuronOutValid = '0;
        do_reset();
        f = '{v: {16'h0A03, 16'h0A02, 16'hF001, 16'h0A00}, c: {8'd1, 8'd0, 8'd5, 8'd4},
              dn: -1, dc: 0, dv: 16'h0, rmode: 0, sstrobe: 1'b0};
        run_frame(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
